// File: rtl/ga_pkg.sv
// ga_pkg: shared GA datapath definitions.
//   - Default fitness / chromosome widths.
//   - worst_fit(maximize): fitness value that every real candidate beats or ties.
//   - is_better(a, b, maximize): strict "a beats b" comparison.
// The helpers work on a 64-bit container so one definition serves any
// FIT_WIDTH up to 64; callers zero-extend unsigned fitness values and
// truncate worst_fit() back to their own width.
package ga_pkg;

    localparam int FIT_WIDTH_DEF   = 27;
    localparam int CHROM_WIDTH_DEF = 8;
    localparam int FIT_MAX_W       = 64;

    typedef logic [FIT_MAX_W-1:0] fit_wide_t;

    function automatic fit_wide_t worst_fit(input logic maximize);
        return maximize ? '0 : '1;
    endfunction

    function automatic logic is_better(input fit_wide_t a, input fit_wide_t b,
                                       input logic maximize);
        return maximize ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/argmin_tree.sv
// argmin_tree: combinational masked best-of-LANES reduction.
//   in_mask   [LANES]               per-lane candidate valid
//   in_fit    [LANES*FIT_WIDTH]     lane i at [i*FIT_WIDTH +: FIT_WIDTH]
//   in_chrom  [LANES*CHROM_WIDTH]   lane i at [i*CHROM_WIDTH +: CHROM_WIDTH]
//   win_valid                       at least one lane masked in
//   win_fit / win_chrom             winning lane (ties -> lowest lane index)
// The lanes are padded to a power of two and reduced as a binary heap; the
// left child always covers lower lane indices, so keeping the left child on
// a tie yields lowest-index tie-breaking.
module argmin_tree
    import ga_pkg::*;
#(
    parameter int FIT_WIDTH   = FIT_WIDTH_DEF,
    parameter int CHROM_WIDTH = CHROM_WIDTH_DEF,
    parameter int LANES       = 2,
    parameter int MAXIMIZE    = 0
) (
    input  logic [LANES-1:0]             in_mask,
    input  logic [LANES*FIT_WIDTH-1:0]   in_fit,
    input  logic [LANES*CHROM_WIDTH-1:0] in_chrom,
    output logic                         win_valid,
    output logic [FIT_WIDTH-1:0]         win_fit,
    output logic [CHROM_WIDTH-1:0]       win_chrom
);

    localparam int LEVELS = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int N      = 1 << LEVELS;
    localparam int NODES  = 2 * N - 1;

    logic [FIT_WIDTH-1:0]   leaf_fit   [N];
    logic [CHROM_WIDTH-1:0] leaf_chrom [N];
    logic                   leaf_vld   [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_leaf
            if (gi < LANES) begin : g_real
                assign leaf_fit[gi]   = in_fit[gi*FIT_WIDTH +: FIT_WIDTH];
                assign leaf_chrom[gi] = in_chrom[gi*CHROM_WIDTH +: CHROM_WIDTH];
                assign leaf_vld[gi]   = in_mask[gi];
            end else begin : g_pad
                assign leaf_fit[gi]   = '0;
                assign leaf_chrom[gi] = '0;
                assign leaf_vld[gi]   = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        logic [FIT_WIDTH-1:0]   nf [NODES];
        logic [CHROM_WIDTH-1:0] nc [NODES];
        logic                   nv [NODES];
        logic                   take_r;
        take_r = 1'b0;
        for (int k = 0; k < NODES; k++) begin
            nf[k] = '0;
            nc[k] = '0;
            nv[k] = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            nf[N-1+k] = leaf_fit[k];
            nc[N-1+k] = leaf_chrom[k];
            nv[N-1+k] = leaf_vld[k];
        end
        // Children have higher heap indices, so walking downward always
        // reads nodes that are already resolved.
        for (int k = N - 2; k >= 0; k--) begin
            take_r = nv[2*k+2] &&
                     (!nv[2*k+1] ||
                      is_better(FIT_MAX_W'(nf[2*k+2]), FIT_MAX_W'(nf[2*k+1]), MAXIMIZE != 0));
            nf[k] = take_r ? nf[2*k+2] : nf[2*k+1];
            nc[k] = take_r ? nc[2*k+2] : nc[2*k+1];
            nv[k] = nv[2*k+1] | nv[2*k+2];
        end
        win_valid = nv[0];
        win_fit   = nf[0];
        win_chrom = nc[0];
    end

endmodule

// File: rtl/best_tracker.sv
// best_tracker: two-stage multi-lane best-individual tracker.
//   Stage 1 reduces up to LANES masked candidates to one winner; stage 2
//   keeps the running generation best and the run-global best.
// Ports:
//   clk, reset (async, active-high), clear (sync restart, same effect)
//   in_valid/in_last/in_mask/in_fit/in_chrom      candidate batch
//   best_fit/best/best_found/improved             global best
//   gen_valid/gen_best_fit/gen_best/gen_found     closed-generation result
//   stall_cnt/stalled                             stagnation indication
// Optional feature: define BEST_TRACKER_STALL_EN to build the stagnation
// counter; without it stall_cnt and stalled are constant 0.
module best_tracker
    import ga_pkg::*;
#(
    parameter int FIT_WIDTH   = FIT_WIDTH_DEF,
    parameter int CHROM_WIDTH = CHROM_WIDTH_DEF,
    parameter int LANES       = 2,
    parameter int MAXIMIZE    = 0,
    parameter int STALL_LIMIT = 16,
    parameter int STALL_W     = $clog2(STALL_LIMIT + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [LANES-1:0]             in_mask,
    input  logic [LANES*FIT_WIDTH-1:0]   in_fit,
    input  logic [LANES*CHROM_WIDTH-1:0] in_chrom,
    output logic [FIT_WIDTH-1:0]         best_fit,
    output logic [CHROM_WIDTH-1:0]       best,
    output logic                         best_found,
    output logic                         improved,
    output logic                         gen_valid,
    output logic [FIT_WIDTH-1:0]         gen_best_fit,
    output logic [CHROM_WIDTH-1:0]       gen_best,
    output logic                         gen_found,
    output logic [STALL_W-1:0]           stall_cnt,
    output logic                         stalled
);

    localparam logic [FIT_WIDTH-1:0] WORST = FIT_WIDTH'(worst_fit(MAXIMIZE != 0));
    localparam logic                 MAXB  = (MAXIMIZE != 0);

    // ---------------- stage 1: lane reduction ----------------
    logic                   tree_valid;
    logic [FIT_WIDTH-1:0]   tree_fit;
    logic [CHROM_WIDTH-1:0] tree_chrom;

    argmin_tree #(
        .FIT_WIDTH  (FIT_WIDTH),
        .CHROM_WIDTH(CHROM_WIDTH),
        .LANES      (LANES),
        .MAXIMIZE   (MAXIMIZE)
    ) u_tree (
        .in_mask  (in_mask),
        .in_fit   (in_fit),
        .in_chrom (in_chrom),
        .win_valid(tree_valid),
        .win_fit  (tree_fit),
        .win_chrom(tree_chrom)
    );

    logic                   s1_valid_reg, s1_last_reg, s1_any_reg;
    logic [FIT_WIDTH-1:0]   s1_fit_reg;
    logic [CHROM_WIDTH-1:0] s1_chrom_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_any_reg   <= 1'b0;
            s1_fit_reg   <= WORST;
            s1_chrom_reg <= '0;
        end else if (clear) begin
            // Drops both the incoming batch and the one already in stage 1.
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_any_reg   <= 1'b0;
            s1_fit_reg   <= WORST;
            s1_chrom_reg <= '0;
        end else begin
            s1_valid_reg <= in_valid;
            s1_last_reg  <= in_valid & in_last;
            s1_any_reg   <= in_valid & tree_valid;
            s1_fit_reg   <= tree_fit;
            s1_chrom_reg <= tree_chrom;
        end
    end

    // ---------------- stage 2: generation / global update ----------------
    logic [FIT_WIDTH-1:0]   gen_run_fit_reg;
    logic [CHROM_WIDTH-1:0] gen_run_chrom_reg;
    logic                   gen_run_found_reg;

    logic [FIT_WIDTH-1:0]   best_fit_reg, gen_best_fit_reg;
    logic [CHROM_WIDTH-1:0] best_reg, gen_best_reg;
    logic                   best_found_reg, improved_reg, gen_valid_reg, gen_found_reg;

    logic                   run_take, glob_take, gen_close;
    logic [FIT_WIDTH-1:0]   merged_fit;
    logic [CHROM_WIDTH-1:0] merged_chrom;
    logic                   merged_found;

    // An empty slot (not yet found) accepts any real candidate, so a
    // candidate sitting exactly at WORST is still recorded as found.
    always_comb begin
        run_take  = s1_any_reg &&
                    (!gen_run_found_reg ||
                     is_better(FIT_MAX_W'(s1_fit_reg), FIT_MAX_W'(gen_run_fit_reg), MAXB));
        glob_take = s1_any_reg &&
                    (!best_found_reg ||
                     is_better(FIT_MAX_W'(s1_fit_reg), FIT_MAX_W'(best_fit_reg), MAXB));
        gen_close    = s1_valid_reg & s1_last_reg;
        merged_fit   = run_take ? s1_fit_reg   : gen_run_fit_reg;
        merged_chrom = run_take ? s1_chrom_reg : gen_run_chrom_reg;
        merged_found = gen_run_found_reg | s1_any_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_run_fit_reg   <= WORST;
            gen_run_chrom_reg <= '0;
            gen_run_found_reg <= 1'b0;
            best_fit_reg      <= WORST;
            best_reg          <= '0;
            best_found_reg    <= 1'b0;
            improved_reg      <= 1'b0;
            gen_valid_reg     <= 1'b0;
            gen_best_fit_reg  <= WORST;
            gen_best_reg      <= '0;
            gen_found_reg     <= 1'b0;
        end else if (clear) begin
            gen_run_fit_reg   <= WORST;
            gen_run_chrom_reg <= '0;
            gen_run_found_reg <= 1'b0;
            best_fit_reg      <= WORST;
            best_reg          <= '0;
            best_found_reg    <= 1'b0;
            improved_reg      <= 1'b0;
            gen_valid_reg     <= 1'b0;
            gen_best_fit_reg  <= WORST;
            gen_best_reg      <= '0;
            gen_found_reg     <= 1'b0;
        end else begin
            improved_reg  <= glob_take;
            gen_valid_reg <= gen_close;
            if (glob_take) begin
                best_fit_reg   <= s1_fit_reg;
                best_reg       <= s1_chrom_reg;
                best_found_reg <= 1'b1;
            end
            if (gen_close) begin
                // Publish the merged result and restart the running best in
                // the same cycle so the next batch opens a fresh generation.
                gen_best_fit_reg  <= merged_fit;
                gen_best_reg      <= merged_chrom;
                gen_found_reg     <= merged_found;
                gen_run_fit_reg   <= WORST;
                gen_run_chrom_reg <= '0;
                gen_run_found_reg <= 1'b0;
            end else if (s1_valid_reg) begin
                gen_run_fit_reg   <= merged_fit;
                gen_run_chrom_reg <= merged_chrom;
                gen_run_found_reg <= merged_found;
            end
        end
    end

    assign best_fit     = best_fit_reg;
    assign best         = best_reg;
    assign best_found   = best_found_reg;
    assign improved     = improved_reg;
    assign gen_valid    = gen_valid_reg;
    assign gen_best_fit = gen_best_fit_reg;
    assign gen_best     = gen_best_reg;
    assign gen_found    = gen_found_reg;

    // ---------------- stagnation counter ----------------
`ifdef BEST_TRACKER_STALL_EN
    localparam logic [STALL_W-1:0] LIMIT = STALL_W'(STALL_LIMIT);

    logic               gen_imp_reg;
    logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic               stalled_reg;

    // An improvement on the closing batch itself also counts for the
    // generation being closed.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (gen_imp_reg || glob_take)
            stall_cnt_next = '0;
        else if (stall_cnt_reg < LIMIT)
            stall_cnt_next = stall_cnt_reg + STALL_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen_imp_reg   <= 1'b0;
            stall_cnt_reg <= '0;
            stalled_reg   <= 1'b0;
        end else if (clear) begin
            gen_imp_reg   <= 1'b0;
            stall_cnt_reg <= '0;
            stalled_reg   <= 1'b0;
        end else if (gen_close) begin
            gen_imp_reg   <= 1'b0;
            stall_cnt_reg <= stall_cnt_next;
            stalled_reg   <= (stall_cnt_next >= LIMIT);
        end else if (glob_take) begin
            gen_imp_reg   <= 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign stalled   = stalled_reg;
`else
    assign stall_cnt = '0;
    assign stalled   = 1'b0;
`endif

endmodule

// File: tb/tb_best_tracker.sv
// tb_best_tracker: scoreboard bench for best_tracker.
//   dut     : LANES=2, minimise, STALL_LIMIT=3; every closing batch pushes its
//             hand-computed generation result, a monitor pops on gen_valid.
//   dut_max : LANES=2, maximise; direct checks of result and clear handling.
module tb_best_tracker;

    localparam int FW = 27;
    localparam int CW = 8;
    localparam logic [FW-1:0] WMIN = 27'h7FFFFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- minimise DUT ----------------
    logic            clear = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [1:0]      in_mask = '0;
    logic [2*FW-1:0] in_fit = '0;
    logic [2*CW-1:0] in_chrom = '0;
    logic [FW-1:0]   best_fit, gen_best_fit;
    logic [CW-1:0]   best, gen_best;
    logic            best_found, improved, gen_valid, gen_found, stalled;
    logic [1:0]      stall_cnt;

    best_tracker #(.FIT_WIDTH(FW), .CHROM_WIDTH(CW), .LANES(2), .MAXIMIZE(0),
                   .STALL_LIMIT(3)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_last(in_last), .in_mask(in_mask), .in_fit(in_fit), .in_chrom(in_chrom),
        .best_fit(best_fit), .best(best), .best_found(best_found),
        .improved(improved), .gen_valid(gen_valid), .gen_best_fit(gen_best_fit),
        .gen_best(gen_best), .gen_found(gen_found), .stall_cnt(stall_cnt),
        .stalled(stalled)
    );

    // ---------------- maximise DUT ----------------
    logic            m_clear = 1'b0, m_valid = 1'b0, m_last = 1'b0;
    logic [1:0]      m_mask = '0;
    logic [2*FW-1:0] m_fit = '0;
    logic [2*CW-1:0] m_chrom = '0;
    logic [FW-1:0]   m_best_fit, m_gen_best_fit;
    logic [CW-1:0]   m_best, m_gen_best;
    logic            m_best_found, m_improved, m_gen_valid, m_gen_found, m_stalled;
    logic [4:0]      m_stall_cnt;

    best_tracker #(.FIT_WIDTH(FW), .CHROM_WIDTH(CW), .LANES(2), .MAXIMIZE(1),
                   .STALL_LIMIT(16)) dut_max (
        .clk(clk), .reset(reset), .clear(m_clear), .in_valid(m_valid),
        .in_last(m_last), .in_mask(m_mask), .in_fit(m_fit), .in_chrom(m_chrom),
        .best_fit(m_best_fit), .best(m_best), .best_found(m_best_found),
        .improved(m_improved), .gen_valid(m_gen_valid), .gen_best_fit(m_gen_best_fit),
        .gen_best(m_gen_best), .gen_found(m_gen_found), .stall_cnt(m_stall_cnt),
        .stalled(m_stalled)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        string         name;
        logic [FW-1:0] bfit;
        logic [CW-1:0] bch;
        logic          bfound;
        logic          imp;
        logic          gfound;
        logic [FW-1:0] gfit;
        logic [CW-1:0] gch;
        int            st;
        logic          stl;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [FW-1:0] bfit, input logic [CW-1:0] bch,
                        input logic imp, input logic gfound, input logic [FW-1:0] gfit,
                        input logic [CW-1:0] gch, input int st, input logic stl);
        exp_t e;
        e.name = nm; e.bfit = bfit; e.bch = bch; e.bfound = 1'b1; e.imp = imp;
        e.gfound = gfound; e.gfit = gfit; e.gch = gch;
`ifdef BEST_TRACKER_STALL_EN
        e.st = st; e.stl = stl;
`else
        e.st = 0; e.stl = 1'b0;
`endif
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && gen_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_gen_valid: got gen_best_fit %0h expected no result", gen_best_fit);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, ".best_fit"},     64'(best_fit),     64'(e.bfit));
                chk({e.name, ".best"},         64'(best),         64'(e.bch));
                chk({e.name, ".best_found"},   64'(best_found),   64'(e.bfound));
                chk({e.name, ".improved"},     64'(improved),     64'(e.imp));
                chk({e.name, ".gen_found"},    64'(gen_found),    64'(e.gfound));
                chk({e.name, ".gen_best_fit"}, 64'(gen_best_fit), 64'(e.gfit));
                chk({e.name, ".gen_best"},     64'(gen_best),     64'(e.gch));
                chk({e.name, ".stall_cnt"},    64'(stall_cnt),    64'(e.st));
                chk({e.name, ".stalled"},      64'(stalled),      64'(e.stl));
                $display("txn %s: best_fit=%0h best=%0h imp=%0b gen_fit=%0h gen_best=%0h gen_found=%0b stall=%0d",
                         e.name, best_fit, best, improved, gen_best_fit, gen_best, gen_found, stall_cnt);
            end
        end
    end

    task automatic send(input logic last, input logic [1:0] mask, input logic [FW-1:0] f0,
                        input logic [FW-1:0] f1, input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        in_valid = 1'b1; in_last = last; in_mask = mask;
        in_fit = {f1, f0}; in_chrom = {c1, c0};
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic m_send(input logic last, input logic [1:0] mask, input logic [FW-1:0] f0,
                          input logic [FW-1:0] f1, input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        m_valid = 1'b1; m_last = last; m_mask = mask;
        m_fit = {f1, f0}; m_chrom = {c1, c0};
        @(posedge clk); #1;
        m_valid = 1'b0; m_last = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk({nm, ".pending_results"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset.best_fit",     64'(best_fit),     64'(WMIN));
        chk("reset.best",         64'(best),         64'd0);
        chk("reset.best_found",   64'(best_found),   64'd0);
        chk("reset.improved",     64'(improved),     64'd0);
        chk("reset.gen_valid",    64'(gen_valid),    64'd0);
        chk("reset.gen_best_fit", 64'(gen_best_fit), 64'(WMIN));
        chk("reset.stall_cnt",    64'(stall_cnt),    64'd0);
        chk("reset.max_best_fit", 64'(m_best_fit),   64'd0);
        @(posedge clk); #1;

        // All generations below are issued back to back.
        push("tie", 27'd40, 8'hA1, 1'b1, 1'b1, 27'd40, 8'hA1, 0, 1'b0);
        send(1'b1, 2'b11, 27'd40, 27'd40, 8'hA1, 8'hB2);
        push("tie_again", 27'd40, 8'hA1, 1'b0, 1'b1, 27'd40, 8'hC3, 1, 1'b0);
        send(1'b1, 2'b01, 27'd40, 27'd0, 8'hC3, 8'h00);
        push("pair", 27'd30, 8'h22, 1'b1, 1'b1, 27'd30, 8'h22, 0, 1'b0);
        send(1'b1, 2'b11, 27'd50, 27'd30, 8'h11, 8'h22);
        push("gen1", 27'd20, 8'h33, 1'b1, 1'b1, 27'd20, 8'h33, 0, 1'b0);
        send(1'b1, 2'b01, 27'd20, 27'd0, 8'h33, 8'h00);
        push("gen2", 27'd20, 8'h33, 1'b0, 1'b1, 27'd25, 8'h44, 1, 1'b0);
        send(1'b1, 2'b01, 27'd25, 27'd0, 8'h44, 8'h00);
        push("empty", 27'd20, 8'h33, 1'b0, 1'b0, WMIN, 8'h00, 2, 1'b0);
        send(1'b1, 2'b00, 27'd1, 27'd1, 8'hEE, 8'hEE);
        push("lane1_only", 27'd20, 8'h33, 1'b0, 1'b1, 27'd100, 8'h55, 3, 1'b1);
        send(1'b1, 2'b10, 27'd0, 27'd100, 8'h00, 8'h55);
        // Two-batch generation: the improvement lands on the first batch.
        send(1'b0, 2'b11, 27'd90, 27'd10, 8'h00, 8'h77);
        push("multi", 27'd10, 8'h77, 1'b0, 1'b1, 27'd10, 8'h77, 0, 1'b0);
        send(1'b1, 2'b01, 27'd12, 27'd0, 8'h88, 8'h00);
        for (int i = 0; i < 4; i++) begin
            push($sformatf("stale%0d", i), 27'd10, 8'h77, 1'b0, 1'b1, 27'd200, 8'h99,
                 (i < 3) ? i + 1 : 3, (i >= 2));
            send(1'b1, 2'b01, 27'd200, 27'd0, 8'h99, 8'h00);
        end
        drain("stream");

        // Asynchronous reset while a non-closing batch sits in stage 1.
        send(1'b0, 2'b01, 27'd5, 27'd0, 8'hAA, 8'h00);
        reset = 1'b1;
        #1;
        chk("async_reset.best_fit",   64'(best_fit),   64'(WMIN));
        chk("async_reset.best_found", 64'(best_found), 64'd0);
        chk("async_reset.best",       64'(best),       64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        push("after_reset", 27'd7, 8'hBB, 1'b1, 1'b1, 27'd7, 8'hBB, 0, 1'b0);
        send(1'b1, 2'b01, 27'd7, 27'd0, 8'hBB, 8'h00);
        drain("after_reset");

        // Maximise instance.
        m_send(1'b1, 2'b11, 27'd5, 27'd9, 8'h05, 8'h09);
        @(posedge clk); #1;
        chk("max.gen_valid",    64'(m_gen_valid),    64'd1);
        chk("max.best_fit",     64'(m_best_fit),     64'd9);
        chk("max.best",         64'(m_best),         64'h09);
        chk("max.improved",     64'(m_improved),     64'd1);
        chk("max.gen_best_fit", 64'(m_gen_best_fit), 64'd9);
        $display("txn max: best_fit=%0h best=%0h", m_best_fit, m_best);

        // clear together with a batch: everything back to reset values.
        m_valid = 1'b1; m_last = 1'b1; m_mask = 2'b11;
        m_fit = {27'd4, 27'd3}; m_chrom = {8'h44, 8'h33}; m_clear = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0; m_last = 1'b0; m_clear = 1'b0;
        chk("clear.best_fit",     64'(m_best_fit),     64'd0);
        chk("clear.best",         64'(m_best),         64'd0);
        chk("clear.best_found",   64'(m_best_found),   64'd0);
        chk("clear.gen_found",    64'(m_gen_found),    64'd0);
        chk("clear.gen_best",     64'(m_gen_best),     64'd0);
        @(posedge clk); #1;
        chk("clear.dropped_gen_valid",  64'(m_gen_valid),  64'd0);
        chk("clear.dropped_best_found", 64'(m_best_found), 64'd0);
        @(posedge clk); #1;
        chk("clear.dropped_late", 64'(m_gen_valid), 64'd0);

        // clear while a batch is in flight in stage 1.
        m_send(1'b1, 2'b01, 27'd3, 27'd0, 8'h03, 8'h00);
        m_clear = 1'b1;
        @(posedge clk); #1;
        m_clear = 1'b0;
        @(posedge clk); #1;
        chk("inflight.gen_valid",  64'(m_gen_valid),  64'd0);
        chk("inflight.best_found", 64'(m_best_found), 64'd0);
        $display("txn clear: best_fit=%0h best_found=%0b", m_best_fit, m_best_found);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/best_tracker.md
# best_tracker

Parametrised multi-lane best-individual tracker for the GA datapath. Each cycle it accepts up to LANES fitness/chromosome pairs from the fitness evaluators, reduces them to a single winner, and maintains both the per-generation best and the run-global best. It sits between the fitness evaluation stage and the controller. It reports the generation result and a stagnation indication the controller uses to terminate or re-seed.

## Interface
- FIT_WIDTH, 27, fitness width (unsigned)
- CHROM_WIDTH, 8, chromosome width
- LANES, 2, candidate pairs per cycle (≥1)
- MAXIMIZE, 0, 0 = lower fitness is better, 1 = higher is better
- STALL_LIMIT, 16, generations without improvement before `stalled` (≥1)
- STALL_W, $clog2(STALL_LIMIT+1), stall counter width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  synchronous run restart; same effect as reset
- in_valid  in  1  batch present this cycle
- in_last  in  1  batch closes current generation (qualified by in_valid)
- in_mask  in  LANES  per-lane candidate valid
- in_fit  in  LANES*FIT_WIDTH  lane i at [i*FIT_WIDTH +: FIT_WIDTH]
- in_chrom  in  LANES*CHROM_WIDTH  lane i at [i*CHROM_WIDTH +: CHROM_WIDTH]
- best_fit  out  FIT_WIDTH  global best fitness
- best  out  CHROM_WIDTH  chromosome of best_fit
- best_found  out  1  global best holds a real candidate
- improved  out  1  one-cycle pulse: global best strictly improved
- gen_valid  out  1  one-cycle pulse: generation result valid
- gen_best_fit  out  FIT_WIDTH  best of closed generation
- gen_best  out  CHROM_WIDTH  chromosome of gen_best_fit
- gen_found  out  1  closed generation contained ≥1 candidate
- stall_cnt  out  STALL_W  consecutive non-improving generations
- stalled  out  1  stall_cnt ≥ STALL_LIMIT

## Operation
- WORST = all ones (MAXIMIZE=0) or all zeros (MAXIMIZE=1). "better" = strict < (or > when MAXIMIZE=1).
- Stage 1 (reduce): among lanes with in_mask set, pick the best; ties go to the lowest lane index. Registers winner fit/chrom, any-valid, last, valid. A fully masked batch registers any-valid=0.
- Stage 2 (update): running generation best (gen_run) is replaced only by a strictly better winner. Ties keep the earlier candidate.
- Global best is updated from the same winner under the same strict rule. When updated: `improved` pulses, best_found=1, and a per-generation improve flag is set.
- On a stage-2 last batch:
  - gen_* outputs load the merged gen_run+winner result and gen_valid pulses.
  - gen_run returns to WORST/not-found in the same cycle. A following batch starts a fresh generation with no bubble.
- Empty generation (no masked-in candidates): gen_valid pulses with gen_found=0 and gen_best_fit=WORST. Counts as non-improving.
- Reset values: best_fit=WORST, best=0, best_found=0, improved=0, gen_valid=0, gen_best_fit=WORST, gen_best=0, gen_found=0, stall_cnt=0, stalled=0, pipeline valids 0.
- clear wins over in_valid in the same cycle; that batch and any in-flight stage-1 batch are discarded.
- No backpressure; a batch is accepted every cycle in_valid=1.

## Timing
- Batch at edge t: stage-1 registered at t+1; best_fit/best/improved/gen_* visible after t+2. Latency 2, throughput 1 batch/cycle.
- stall_cnt/stalled update at the same edge as gen_valid. Improvement inside that generation (including the last batch) → 0. Otherwise +1, saturating at STALL_LIMIT.
- Reset mid-generation: immediate asynchronous clear; partial generation is lost, no gen_valid.

## Configuration
- BEST_TRACKER_STALL_EN defined: stagnation counter and `stalled` operate as above.
- Undefined: counter logic omitted; stall_cnt and stalled tied to 0, ports retained.

## Structure
- ga_pkg: FIT_WIDTH/CHROM_WIDTH defaults, `worst_fit(maximize)` and `is_better(a,b,maximize)` functions shared with selection logic.
- Sub-module `argmin_tree`: combinational log2(LANES) reduction with mask and lowest-index tie-break. Instantiated once in stage 1.

## Test plan
- LANES=2, minimize: batch fit={50,30}, mask=11, last → after 2 cycles best_fit=30, best=lane1 chrom, improved=1, gen_valid=1, gen_best_fit=30.
- Tie: fit={40,40}, chroms {0xA1,0xB2} → best=0xA1. A later batch with 40 → best unchanged, improved=0.
- Back-to-back generations: gen1 {20}, last; next cycle gen2 {25}, last → gen_best_fit 20 then 25. best_fit stays 20, stall_cnt=1.
- Empty generation: mask=00, last → gen_valid=1, gen_found=0, gen_best_fit=0x7FFFFFF.
- STALL_LIMIT=3, macro on: 3 non-improving generations → stalled=1 on the third gen_valid. An improving generation → stall_cnt=0.
- MAXIMIZE=1: {5,9} → best_fit=9. clear asserted alongside in_valid → all outputs back to reset values, batch dropped.
